// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcode, ALU-op and ID/EX payload definitions
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_t;

    typedef struct packed {
        logic alu_src;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
        logic branch;
        logic jump;
    } ctrl_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        alu_op_t     alu_op;
        ctrl_t       ctrl;
        logic        illegal;
    } idex_t;

    // alt is the instr[30] qualifier, already gated by the caller for the opcode class
    function automatic alu_op_t alu_from_funct3(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  alu_from_funct3 = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_from_funct3 = ALU_SLL;
            3'b010:  alu_from_funct3 = ALU_SLT;
            3'b011:  alu_from_funct3 = ALU_SLTU;
            3'b100:  alu_from_funct3 = ALU_XOR;
            3'b101:  alu_from_funct3 = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_from_funct3 = ALU_OR;
            default: alu_from_funct3 = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/instruction_decode_if.sv
// rtl/instruction_decode_if.sv - fetch, writeback and ID/EX signal bundle of the decode stage
interface instruction_decode_if;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic        ex_mem_to_reg;
    logic        ex_branch;
    logic        ex_jump;
    logic        load_use_stall;
    logic        illegal;

    modport master (
        output if_pc, if_instr, if_valid, flush, wb_we, wb_rd, wb_data,
        input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
        input  ex_rs1, ex_rs2, ex_rd, ex_alu_op,
        input  ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
        input  ex_mem_to_reg, ex_branch, ex_jump, load_use_stall, illegal
    );

    modport slave (
        input  if_pc, if_instr, if_valid, flush, wb_we, wb_rd, wb_data,
        output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
        output ex_rs1, ex_rs2, ex_rd, ex_alu_op,
        output ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
        output ex_mem_to_reg, ex_branch, ex_jump, load_use_stall, illegal
    );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 register file, two async reads with write-through bypass
module register_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data,
    input  logic        i_we,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_wdata
);

    logic [31:0] r_regs [32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_rd != 5'd0)) begin
            r_regs[i_rd] <= i_wdata;
        end
    end

    // x0 is forced to zero on read, so entry 0 is never consulted
    always_comb begin
        o_rs1_data = '0;
        o_rs2_data = '0;
        if (i_rs1_addr != 5'd0) begin
            o_rs1_data = (i_we && (i_rd == i_rs1_addr)) ? i_wdata : r_regs[i_rs1_addr];
        end
        if (i_rs2_addr != 5'd0) begin
            o_rs2_data = (i_we && (i_rd == i_rs2_addr)) ? i_wdata : r_regs[i_rs2_addr];
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - RV32I decode stage: decode, immediates, load-use stall, ID/EX register
module instruction_decode
    import riscv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    instruction_decode_if.slave  bus
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [31:0] w_instr;
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;
    logic        w_legal;
    logic        w_uses_rs1;
    logic        w_uses_rs2;
    logic [31:0] w_imm;
    alu_op_t     w_alu_op;
    ctrl_t       w_ctrl;
    logic        w_stall;
    idex_t       w_next;
    idex_t       r_idex;

    assign w_instr  = bus.if_instr;
    assign w_opcode = w_instr[6:0];
    assign w_rd     = w_instr[11:7];
    assign w_funct3 = w_instr[14:12];
    assign w_rs1    = w_instr[19:15];
    assign w_rs2    = w_instr[24:20];

    register_file u_register_file (
        .clk        (clk),
        .rst        (rst),
        .i_rs1_addr (w_rs1),
        .i_rs2_addr (w_rs2),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data),
        .i_we       (bus.wb_we),
        .i_rd       (bus.wb_rd),
        .i_wdata    (bus.wb_data)
    );

    always_comb begin
        w_legal    = 1'b1;
        w_uses_rs1 = 1'b0;
        w_uses_rs2 = 1'b0;
        w_imm      = '0;
        w_alu_op   = ALU_ADD;
        w_ctrl     = '0;
        case (w_opcode)
            OPC_OP: begin
                w_uses_rs1       = 1'b1;
                w_uses_rs2       = 1'b1;
                w_alu_op         = alu_from_funct3(w_funct3, w_instr[30]);
                w_ctrl.reg_write = 1'b1;
            end
            OPC_OP_IMM: begin
                w_uses_rs1       = 1'b1;
                w_imm            = {{20{w_instr[31]}}, w_instr[31:20]};
                // only the shift-right form takes the arithmetic qualifier; ADDI never becomes SUB
                w_alu_op         = alu_from_funct3(w_funct3, w_instr[30] && (w_funct3 == 3'b101));
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                w_uses_rs1        = 1'b1;
                w_imm             = {{20{w_instr[31]}}, w_instr[31:20]};
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
            end
            OPC_STORE: begin
                w_uses_rs1       = 1'b1;
                w_uses_rs2       = 1'b1;
                w_imm            = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                w_uses_rs1    = 1'b1;
                w_uses_rs2    = 1'b1;
                w_imm         = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                                 w_instr[30:25], w_instr[11:8], 1'b0};
                w_alu_op      = ALU_SUB;
                w_ctrl.branch = 1'b1;
            end
            OPC_JAL: begin
                w_imm            = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                                    w_instr[20], w_instr[30:21], 1'b0};
                w_ctrl.reg_write = 1'b1;
                w_ctrl.jump      = 1'b1;
            end
            OPC_JALR: begin
                w_uses_rs1       = 1'b1;
                w_imm            = {{20{w_instr[31]}}, w_instr[31:20]};
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.jump      = 1'b1;
            end
            OPC_LUI: begin
                w_imm            = {w_instr[31:12], 12'h000};
                w_alu_op         = ALU_PASSB;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                w_imm            = {w_instr[31:12], 12'h000};
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // unused source fields never stall, so an I-type whose rs2 bits alias the load target issues freely
    assign w_stall = r_idex.valid && r_idex.ctrl.mem_read && (r_idex.rd != 5'd0) && bus.if_valid &&
                     ((w_uses_rs1 && (w_rs1 == r_idex.rd)) || (w_uses_rs2 && (w_rs2 == r_idex.rd)));

    always_comb begin
        w_next = '0;
        if (bus.flush || w_stall || !bus.if_valid) begin
            w_next = '0;
        end else if (!w_legal) begin
            w_next.valid   = 1'b1;
            w_next.pc      = bus.if_pc;
            w_next.illegal = 1'b1;
        end else begin
            w_next.valid    = 1'b1;
            w_next.pc       = bus.if_pc;
            w_next.rs1_data = w_rs1_data;
            w_next.rs2_data = w_rs2_data;
            w_next.imm      = w_imm;
            w_next.rs1      = w_uses_rs1 ? w_rs1 : 5'd0;
            w_next.rs2      = w_uses_rs2 ? w_rs2 : 5'd0;
            w_next.rd       = w_ctrl.reg_write ? w_rd : 5'd0;
            w_next.alu_op   = w_alu_op;
            w_next.ctrl     = w_ctrl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idex <= '0;
        end else begin
            r_idex <= w_next;
        end
    end

    assign bus.ex_valid       = r_idex.valid;
    assign bus.ex_pc          = r_idex.pc;
    assign bus.ex_rs1_data    = r_idex.rs1_data;
    assign bus.ex_rs2_data    = r_idex.rs2_data;
    assign bus.ex_imm         = r_idex.imm;
    assign bus.ex_rs1         = r_idex.rs1;
    assign bus.ex_rs2         = r_idex.rs2;
    assign bus.ex_rd          = r_idex.rd;
    assign bus.ex_alu_op      = r_idex.alu_op;
    assign bus.ex_alu_src     = r_idex.ctrl.alu_src;
    assign bus.ex_mem_read    = r_idex.ctrl.mem_read;
    assign bus.ex_mem_write   = r_idex.ctrl.mem_write;
    assign bus.ex_reg_write   = r_idex.ctrl.reg_write;
    assign bus.ex_mem_to_reg  = r_idex.ctrl.mem_to_reg;
    assign bus.ex_branch      = r_idex.ctrl.branch;
    assign bus.ex_jump        = r_idex.ctrl.jump;
    assign bus.illegal        = r_idex.illegal;
    assign bus.load_use_stall = w_stall;

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 SHALL: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL: if_pc  in  32  PC of the fetched instruction.
REQ-004 SHALL: if_instr  in  32  fetched instruction word.
REQ-005 SHALL: if_valid  in  1  fetched word valid; 0 means bubble.
REQ-006 SHALL: flush  in  1  branch/jump taken in EX; kill the instruction now in ID.
REQ-007 SHALL: wb_we, wb_rd, wb_data  in  1/5/32  register-file write port from WB.
REQ-008 SHALL: ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  1/32/32/32/32  registered ID/EX payload.
REQ-009 SHALL: ex_rs1, ex_rs2, ex_rd  out  5 each  registered register indices, for the forwarding unit.
REQ-010 SHALL: ex_alu_op  out  4  registered ALU operation, encoded per the shared package.
REQ-011 SHALL: ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch, ex_jump  out  1 each  registered control bits.
REQ-012 SHALL: load_use_stall  out  1  combinational stall request to the fetch stage.
REQ-013 SHALL: illegal  out  1  registered; the instruction now in EX has an unsupported opcode.

Function
REQ-014 SHALL: decode RV32I opcodes R, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI and AUIPC.
REQ-015 SHALL: generate sign-extended I/S/B/U/J immediates; B and J immediates have bit0 = 0; the U immediate is instr[31:12]<<12.
REQ-016 SHALL: ALU ops are ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU and PASSB; SUB/SRA are selected by instr[30] only for R-type, SRAI by instr[30] for OP-IMM, and LUI uses PASSB.
REQ-017 SHALL: the register file is 32x32 with x0 reading 0 always; writes to x0 are ignored.
REQ-018 SHALL: the register file writes on the clock edge when wb_we=1.
REQ-019 SHALL: write-through bypass: if wb_we=1 and wb_rd = rs (rs != 0), the read returns wb_data in the same cycle.
REQ-020 SHALL: load_use_stall = 1 when ex_valid & ex_mem_read & ex_rd != 0 & ex_rd matches an rs1/rs2 actually used by the current valid instruction.
REQ-021 SHALL: the ID/EX register updates every cycle; latency is 1 cycle from if_* to ex_*.
REQ-022 SHALL: load a bubble (ex_valid=0 and all control bits 0) when flush=1, load_use_stall=1 or if_valid=0.
REQ-023 SHALL: flush takes priority over load_use_stall; an unsupported opcode loads illegal=1 with all control bits 0 and ex_valid=1.
REQ-024 SHALL: on a stalled cycle, the fetch stage holds if_*, and the same instruction is decoded again on the next cycle.

Reset
REQ-025 SHALL: rst=1 asynchronously clears all ex_* outputs, illegal and every register-file entry to 0.
REQ-026 SHALL: a reset asserted mid-stall drops the pending instruction; the first edge after release samples if_*.

Structure
REQ-027 SHALL: opcode constants, the ALU-op encoding (ADD=0 … PASSB=10) and the NOP value 0x00000013 live in shared package riscv_pkg.
REQ-028 SHALL: the register file is the sub-module register_file (2 async read ports, 1 write port, bypass included).
REQ-029 SHALL: the decode and immediate logic is combinational, followed by one ID/EX register block.

Verification
REQ-030 SHALL: if_instr=0x00500093 valid -> next cycle ex_rd=1, ex_imm=5, ex_alu_op=ADD, ex_alu_src=1, ex_reg_write=1.
REQ-031 SHALL: wb_we=1, wb_rd=1, wb_data=5 while decoding 0x002081B3 -> ex_rs1_data=5 in the same cycle it is registered.
REQ-032 SHALL: ex holds lw x11 (0x00012583), ID sees add x12,x11,x1 -> load_use_stall=1, next ex_valid=0, then the add issues.
REQ-033 SHALL: flush=1 with load_use_stall=1 -> bubble, and illegal=0 on the next cycle.
REQ-034 SHALL: if_instr=0xFFFFFFFF -> illegal=1, ex_valid=1, all control bits 0.
REQ-035 SHALL: rst pulsed mid-stream -> all ex_* outputs 0 immediately, and x1 reads 0 afterwards.
